// File: rtl/pe_seq_ctrl_if.sv
// Issue-side and datapath-side signal bundle for pe_seq_ctrl.
// Optional perf counter ports are present only when PE_SEQ_PERF_EN is defined.
interface pe_seq_ctrl_if #(
    parameter int unsigned VLEN    = 128,
    parameter int unsigned VREG_AW = 5
);
    localparam int unsigned WORDS = VLEN / 32;
    localparam int unsigned WAW   = $clog2(WORDS);
    localparam int unsigned AW    = VREG_AW + WAW;
    localparam int unsigned VLW   = $clog2(VLEN / 8) + 1;

    logic               issue_valid;
    logic               issue_ready;
    logic [VREG_AW-1:0] issue_vd;
    logic [VREG_AW-1:0] issue_vs1;
    logic [VREG_AW-1:0] issue_vs2;
    logic [VLW-1:0]     issue_vl;
    logic [1:0]         issue_vsew;
    logic [1:0]         issue_widening;
    logic [3:0]         issue_op;
    logic               stall;
    logic               rd_en;
    logic [AW-1:0]      rd_addr_a;
    logic [AW-1:0]      rd_addr_b;
    logic [AW-1:0]      rd_addr_c;
    logic [1:0]         src_part;
    logic [3:0]         pe_op;
    logic [1:0]         pe_vsew;
    logic [1:0]         pe_widening;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [3:0]         wb_be;
    logic               busy;
    logic               done;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]        perf_busy_cycles;
    logic [31:0]        perf_stall_cycles;
`endif

    modport master (
        output issue_valid, issue_vd, issue_vs1, issue_vs2, issue_vl,
               issue_vsew, issue_widening, issue_op, stall,
        input  issue_ready, rd_en, rd_addr_a, rd_addr_b, rd_addr_c, src_part,
               pe_op, pe_vsew, pe_widening, wb_en, wb_addr, wb_be, busy, done
`ifdef PE_SEQ_PERF_EN
        , input perf_busy_cycles, perf_stall_cycles
`endif
    );

    modport slave (
        input  issue_valid, issue_vd, issue_vs1, issue_vs2, issue_vl,
               issue_vsew, issue_widening, issue_op, stall,
        output issue_ready, rd_en, rd_addr_a, rd_addr_b, rd_addr_c, src_part,
               pe_op, pe_vsew, pe_widening, wb_en, wb_addr, wb_be, busy, done
`ifdef PE_SEQ_PERF_EN
        , output perf_busy_cycles, perf_stall_cycles
`endif
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Word-by-word sequencer for one vector instruction on a 32-bit PE.
// Define PE_SEQ_PERF_EN to add saturating busy/stall cycle counters.
module pe_seq_ctrl #(
    parameter int unsigned VLEN    = 128,
    parameter int unsigned VREG_AW = 5
) (
    input  logic         clk,
    input  logic         n_reset,
    pe_seq_ctrl_if.slave bus
);
    localparam int unsigned WORDS = VLEN / 32;
    localparam int unsigned WAW   = $clog2(WORDS);
    localparam int unsigned VLW   = $clog2(VLEN / 8) + 1;
    localparam int unsigned DBW   = VLW + 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [VREG_AW-1:0] vd_q, vs1_q, vs2_q;
    logic [3:0]         op_q;
    logic [1:0]         vsew_q, wid_q;
    logic [WAW:0]       nwords_q;
    logic [3:0]         last_be_q;
    logic [WAW-1:0]     idx;
    logic               s1_valid;
    logic [WAW-1:0]     s1_idx;
    logic [3:0]         s1_be;

    logic [2:0]         shamt;
    logic [DBW-1:0]     dst_bytes;
    logic [DBW-1:0]     nw_raw;
    logic [WAW:0]       nw;
    logic [3:0]         be_calc;
    logic               last_word;
    logic [WAW+1:0]     idx_x;

    // Clamped instructions end on a full word, so only a short final word gets a partial mask.
    always_comb begin
        shamt     = {1'b0, bus.issue_vsew} + {1'b0, bus.issue_widening};
        dst_bytes = DBW'(bus.issue_vl) << shamt;
        nw_raw    = (dst_bytes + DBW'(3)) >> 2;
        nw        = (nw_raw > DBW'(WORDS)) ? (WAW+1)'(WORDS) : nw_raw[WAW:0];
        be_calc   = 4'hF;
        if (dst_bytes < DBW'(VLEN / 8)) begin
            case (dst_bytes[1:0])
                2'd1:    be_calc = 4'b0001;
                2'd2:    be_calc = 4'b0011;
                2'd3:    be_calc = 4'b0111;
                default: be_calc = 4'hF;
            endcase
        end
    end

    assign last_word = ({1'b0, idx} == (nwords_q - (WAW+1)'(1)));
    assign idx_x     = {2'b00, idx};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            vd_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            op_q      <= '0;
            vsew_q    <= '0;
            wid_q     <= '0;
            nwords_q  <= '0;
            last_be_q <= '0;
            idx       <= '0;
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_be     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.issue_valid) begin
                    vd_q      <= bus.issue_vd;
                    vs1_q     <= bus.issue_vs1;
                    vs2_q     <= bus.issue_vs2;
                    op_q      <= bus.issue_op;
                    vsew_q    <= bus.issue_vsew;
                    wid_q     <= bus.issue_widening;
                    nwords_q  <= nw;
                    last_be_q <= be_calc;
                    idx       <= '0;
                    state     <= (nw == '0) ? DONE : RUN;
                end
                RUN: if (!bus.stall) begin
                    idx      <= idx + WAW'(1);
                    s1_valid <= 1'b1;
                    s1_idx   <= idx;
                    s1_be    <= last_word ? last_be_q : 4'hF;
                    if (last_word) state <= DRAIN;
                end
                // The final word leaves stage 1 on this same edge, so DONE follows directly.
                DRAIN: if (!bus.stall) begin
                    s1_valid <= 1'b0;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.issue_ready = (state == IDLE);
    assign bus.busy        = (state == RUN) || (state == DRAIN);
    assign bus.done        = (state == DONE);
    assign bus.rd_en       = (state == RUN) && !bus.stall;
    assign bus.rd_addr_a   = {vs2_q, idx >> wid_q};
    assign bus.rd_addr_b   = {vs1_q, idx >> wid_q};
    assign bus.rd_addr_c   = {vd_q, idx};
    assign bus.src_part    = (wid_q == 2'd0) ? 2'd0 :
                             (wid_q == 2'd1) ? {1'b0, idx_x[0]} : idx_x[1:0];
    assign bus.pe_op       = op_q;
    assign bus.pe_vsew     = vsew_q;
    assign bus.pe_widening = wid_q;
    assign bus.wb_en       = s1_valid && !bus.stall;
    assign bus.wb_addr     = {vd_q, s1_idx};
    assign bus.wb_be       = s1_be;

`ifdef PE_SEQ_PERF_EN
    logic [31:0] busy_cnt, stall_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.busy && (busy_cnt != '1)) busy_cnt <= busy_cnt + 32'd1;
            if (bus.busy && bus.stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.perf_busy_cycles  = busy_cnt;
    assign bus.perf_stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed self-checking bench for pe_seq_ctrl (VLEN=128, VREG_AW=5).
// Word addresses are {reg, word}, i.e. reg*4 + word for this configuration.
module tb_pe_seq_ctrl;
    localparam int unsigned VLEN    = 128;
    localparam int unsigned VREG_AW = 5;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.VLEN(VLEN), .VREG_AW(VREG_AW)) bus ();
    pe_seq_ctrl #(.VLEN(VLEN), .VREG_AW(VREG_AW)) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    int rd_a[$], rd_b[$], rd_c[$], sp[$], wb_a[$], wb_be[$];
    int done_cyc, ready_after, op_seen;

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic run_instr(input int vd, input int vs1, input int vs2, input int vl,
                             input int vsew, input int wid, input int op,
                             input int stall_at, input int stall_len);
        rd_a.delete(); rd_b.delete(); rd_c.delete(); sp.delete();
        wb_a.delete(); wb_be.delete();
        done_cyc = -1;
        op_seen  = -1;
        @(negedge clk);
        bus.issue_valid    = 1'b1;
        bus.issue_vd       = VREG_AW'(vd);
        bus.issue_vs1      = VREG_AW'(vs1);
        bus.issue_vs2      = VREG_AW'(vs2);
        bus.issue_vl       = 5'(vl);
        bus.issue_vsew     = 2'(vsew);
        bus.issue_widening = 2'(wid);
        bus.issue_op       = 4'(op);
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            bus.stall = (k >= stall_at) && (k < stall_at + stall_len);
            @(negedge clk);
            if (bus.rd_en) begin
                rd_a.push_back(int'(bus.rd_addr_a));
                rd_b.push_back(int'(bus.rd_addr_b));
                rd_c.push_back(int'(bus.rd_addr_c));
                sp.push_back(int'(bus.src_part));
                if (op_seen < 0) op_seen = int'(bus.pe_op);
            end
            if (bus.wb_en) begin
                wb_a.push_back(int'(bus.wb_addr));
                wb_be.push_back(int'(bus.wb_be));
            end
            if (bus.done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.stall = 1'b0;
        @(posedge clk);
        #1 ready_after = int'(bus.issue_ready);
    endtask

    // Expected read/write pattern for an instruction of n words (wid = widening shift).
    task automatic verify(input string tag, input int n, input int vd, input int vs1,
                          input int vs2, input int wid, input int last_be,
                          input int done_exp, input int op);
        check({tag, "_done_cycle"}, done_cyc, done_exp);
        check({tag, "_ready_after_done"}, ready_after, 1);
        check({tag, "_num_reads"}, rd_c.size(), n);
        check({tag, "_num_writes"}, wb_a.size(), n);
        if (n > 0) check({tag, "_pe_op"}, op_seen, op);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_rd_c%0d", tag, i), qget(rd_c, i), vd * 4 + i);
            check($sformatf("%s_rd_a%0d", tag, i), qget(rd_a, i), vs2 * 4 + (i >> wid));
            check($sformatf("%s_rd_b%0d", tag, i), qget(rd_b, i), vs1 * 4 + (i >> wid));
            check($sformatf("%s_src_part%0d", tag, i), qget(sp, i), i % (1 << wid));
            check($sformatf("%s_wb_addr%0d", tag, i), qget(wb_a, i), vd * 4 + i);
            check($sformatf("%s_wb_be%0d", tag, i), qget(wb_be, i), (i == n - 1) ? last_be : 15);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_vd = '0; bus.issue_vs1 = '0; bus.issue_vs2 = '0;
        bus.issue_vl = '0; bus.issue_vsew = '0; bus.issue_widening = '0;
        bus.issue_op = '0; bus.stall = 1'b0;
        #1;
        check("rst_issue_ready", bus.issue_ready, 1);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_wb_en", bus.wb_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_wb_be", bus.wb_be, 0);
        check("rst_rd_addr_c", bus.rd_addr_c, 0);
        @(negedge clk);
        n_reset = 1'b1;

        // 32-bit elements, 4 full words
        run_instr(3, 1, 2, 4, 2, 0, 5, 0, 0);
        verify("w32", 4, 3, 1, 2, 0, 15, 6, 5);
        // 5 bytes: second word carries one byte
        run_instr(4, 5, 6, 5, 0, 0, 9, 0, 0);
        verify("b5", 2, 4, 5, 6, 0, 1, 4, 9);
        // 16-bit doubled to 32-bit: sources advance every other word
        run_instr(7, 1, 2, 4, 1, 1, 3, 0, 0);
        verify("wide2", 4, 7, 1, 2, 1, 15, 6, 3);
        // 8-bit quadrupled: one source word feeds four destination words
        run_instr(6, 3, 5, 4, 0, 2, 12, 0, 0);
        verify("wide4", 4, 6, 3, 5, 2, 15, 6, 12);
        // empty instruction
        run_instr(3, 1, 2, 0, 2, 0, 1, 0, 0);
        verify("vl0", 0, 3, 1, 2, 0, 15, 1, 1);
        // 3 halfwords = 6 bytes
        run_instr(2, 0, 0, 3, 1, 0, 7, 0, 0);
        verify("h3", 2, 2, 0, 0, 0, 3, 4, 7);
        // 64 bytes requested, clamped to one 16-byte register
        run_instr(1, 2, 3, 16, 2, 0, 4, 0, 0);
        verify("clamp", 4, 1, 2, 3, 0, 15, 6, 4);
        // stall in cycles 2..4 delays done by exactly 3
        run_instr(3, 1, 2, 4, 2, 0, 5, 2, 3);
        verify("stall", 4, 3, 1, 2, 0, 15, 9, 5);

        // reset in the middle of RUN
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_vd = 5'd3; bus.issue_vs1 = 5'd1; bus.issue_vs2 = 5'd2;
        bus.issue_vl = 5'd4; bus.issue_vsew = 2'd2; bus.issue_widening = 2'd0;
        bus.issue_op = 4'd6;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("arst_rd_en", bus.rd_en, 0);
        check("arst_wb_en", bus.wb_en, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_issue_ready", bus.issue_ready, 1);
        check("arst_rd_addr_c", bus.rd_addr_c, 0);
        check("arst_wb_addr", bus.wb_addr, 0);
        check("arst_pe_op", bus.pe_op, 0);
`ifdef PE_SEQ_PERF_EN
        check("arst_perf_busy", bus.perf_busy_cycles, 0);
        check("arst_perf_stall", bus.perf_stall_cycles, 0);
`endif
        @(negedge clk);
        check("arst_hold_rd_en", bus.rd_en, 0);
        check("arst_hold_done", bus.done, 0);
        n_reset = 1'b1;

        run_instr(3, 1, 2, 4, 2, 0, 5, 0, 0);
        verify("post_rst", 4, 3, 1, 2, 0, 15, 6, 5);
`ifdef PE_SEQ_PERF_EN
        check("perf_busy_a", bus.perf_busy_cycles, 5);
        check("perf_stall_a", bus.perf_stall_cycles, 0);
        run_instr(3, 1, 2, 4, 2, 0, 5, 2, 3);
        verify("perf_stall_run", 4, 3, 1, 2, 0, 15, 9, 5);
        check("perf_busy_b", bus.perf_busy_cycles, 13);
        check("perf_stall_b", bus.perf_stall_cycles, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
